sm_accum_ctrl: RTL
==================

# sm_accum_ctrl

Sequencing controller for the shared 21-bit sign-magnitude adder in the ANC filter datapath. It sums a job of N_TERMS sign-magnitude terms, such as tap products or weight updates, through one adder instance, one term per cycle. Terms arrive over a valid/ready stream and the result leaves over a valid/ready handshake. It sits between the tap multiplier output and the error/weight-update stage.

## Interface
- `N_TERMS`, default 8: terms per job, range 2..256.
- `CNT_W`, default 8: width of the term counter. Must satisfy 2^CNT_W >= N_TERMS.
- `clk` input, 1 bit: single clock. All logic is on the rising edge.
- `rst` input, 1 bit: synchronous, active-high reset.
- `start` input, 1 bit: begins a job. Sampled only in IDLE.
- `term_valid` input, 1 bit: `term` is valid.
- `term` input, 21 bits: sign-magnitude term. Bit 20 is the sign (1 = negative); bits 19:0 are the magnitude.
- `term_ready` output, 1 bit: block accepts a term this cycle.
- `sum_valid` output, 1 bit: `sum` and `ovf` are valid.
- `sum_ready` input, 1 bit: consumer accepts the sum.
- `sum` output, 21 bits: sign-magnitude job result.
- `ovf` output, 1 bit: at least one saturation event occurred in this job.
- `busy` output, 1 bit: state is not IDLE.

## Operation
- **States:** IDLE, ACCUM, DONE.
  - IDLE → ACCUM when `start`=1. On that edge: acc := +0, cnt := 0, ovf := 0.
  - ACCUM: `term_ready`=1. On each accept (`term_valid & term_ready`): acc := acc ⊕ term, cnt := cnt+1. The accept with cnt = N_TERMS-1 moves the state to DONE.
  - DONE: `sum_valid`=1. `sum`=acc and `ovf` are held stable. On `sum_valid & sum_ready` → IDLE.
- `start` is ignored in ACCUM and DONE. No queuing.
- **⊕ (sign-magnitude add):**
  - Inputs with magnitude 0 are treated as +0, whatever their sign bit.
  - Same signs: mag = |a|+|b| using a 21-bit intermediate; the result keeps the common sign. A carry out of bit 19 saturates the magnitude to 0xFFFFF and sets `ovf` (sticky until the next start).
  - Different signs: mag = larger magnitude − smaller magnitude; the result takes the sign of the larger. Equal magnitudes give +0.
  - A result magnitude of 0 always has sign 0. The block never outputs negative zero.
- Accumulation continues from a saturated acc. Later opposite-sign terms reduce it normally.

## Timing
- **Reset:** state=IDLE, acc=0, cnt=0. Outputs: `term_ready`=0, `sum_valid`=0, `sum`=0, `ovf`=0, `busy`=0.
  - Reset mid-job discards all partial state. No sum is emitted.
  - `rst` has priority over every other input in the same cycle.
- `start` at edge k → `term_ready`=1 and `busy`=1 from cycle k+1.
- The adder is combinational between the term port and the acc register. Each term is accepted in one cycle, so throughput is 1 term/cycle.
- The last term accepted at edge m → `sum_valid`=1 in cycle m+1 with the final `sum`. Minimum job length is N_TERMS+2 cycles, start to sum.
- `term_ready` is 0 in IDLE and DONE. A `term_valid` seen there is not consumed.
- Handshake at edge d → `sum_valid`=0 and `busy`=0 from cycle d+1. The next `start` is sampled at edge d+1 or later.
- `sum` holds its last value after the handshake until the next start clears acc.

## Structure
- **Package `sm_pkg`:**
  - Constants: SM_W=21, MAG_W=20, MAG_MAX=20'hFFFFF.
  - State enum type: IDLE/ACCUM/DONE.
  - Typedef: sign-magnitude word.
- **Sub-module `sm_add_sat`:** combinational ⊕ with zero normalisation and a saturation flag output. It is instantiated once inside the controller.
- **Controller body:** FSM, cnt register, acc register, ovf register. No other sub-modules.

## Test plan
1. **Mixed-sign sum.** N_TERMS=4; terms 0x000005, 0x000007, 0x100003, 0x000001, back-to-back → `sum`=0x00000A, `ovf`=0, `sum_valid` exactly 1 cycle after the 4th accept.
2. **Negative-zero handling.** Terms 0x000003, 0x100003, 0x100000, 0x000000 → `sum`=0x000000. Bit 20 must be 0.
3. **Negative result.** Terms 0x100010, 0x000004, 0x100002, 0x000000 → `sum`=0x10000E.
4. **Saturation.** Terms 0x0FFFFF, 0x000001, 0x100005, 0x000000 → `sum`=0x0FFFFA and `ovf`=1. A following job of four 0x000001 terms → `sum`=0x000004, `ovf`=0.
5. **Backpressure.** `term_valid` toggled 1,0,0,1,… during a job; `sum_ready` held 0 for 5 cycles with `start` pulsed during DONE → `sum`/`ovf` stable, `start` ignored, IDLE entered the cycle after `sum_ready`=1.
6. **Reset mid-job.** `rst` asserted after 2 of 4 accepts → all outputs 0 the next cycle and no `sum_valid`. A new job of 1,2,3,4 → `sum`=0x00000A.

Source files
------------

// File: rtl/sm_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sm_pkg
// Description : Shared constants and types for the sign-magnitude accumulator.
// Revision    : 1.0 - initial release
// ============================================================================
package sm_pkg;

    localparam int SM_W  = 21;
    localparam int MAG_W = 20;
    localparam logic [MAG_W-1:0] MAG_MAX = 20'hFFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_t;

    // Bit 20 is the sign (1 = negative), bits 19:0 the magnitude.
    typedef logic [SM_W-1:0] sm_word_t;

endpackage : sm_pkg
`default_nettype wire

// File: rtl/sm_add_sat.sv
`default_nettype none
// ============================================================================
// Module      : sm_add_sat
// Description : Combinational sign-magnitude adder with magnitude saturation.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_add_sat
    import sm_pkg::*;
(
    input  logic [SM_W-1:0] a,
    input  logic [SM_W-1:0] b,
    output logic [SM_W-1:0] y,
    output logic            sat
);

    logic [MAG_W-1:0] w_a_mag;
    logic [MAG_W-1:0] w_b_mag;
    logic             w_a_neg;
    logic             w_b_neg;
    logic [MAG_W:0]   w_mag_sum;
    logic [MAG_W-1:0] w_mag;
    logic             w_sign;

    assign w_a_mag = a[MAG_W-1:0];
    assign w_b_mag = b[MAG_W-1:0];
    // A zero magnitude counts as +0 regardless of its sign bit.
    assign w_a_neg = a[SM_W-1] & (|w_a_mag);
    assign w_b_neg = b[SM_W-1] & (|w_b_mag);
    assign w_mag_sum = {1'b0, w_a_mag} + {1'b0, w_b_mag};

    always_comb begin
        w_mag  = '0;
        w_sign = 1'b0;
        sat    = 1'b0;
        if (w_a_neg == w_b_neg) begin
            w_sign = w_a_neg;
            if (w_mag_sum[MAG_W]) begin
                sat   = 1'b1;
                w_mag = MAG_MAX;
            end else begin
                w_mag = w_mag_sum[MAG_W-1:0];
            end
        end else if (w_a_mag >= w_b_mag) begin
            w_mag  = w_a_mag - w_b_mag;
            w_sign = w_a_neg;
        end else begin
            w_mag  = w_b_mag - w_a_mag;
            w_sign = w_b_neg;
        end
    end

    assign y = {w_sign & (|w_mag), w_mag};

endmodule : sm_add_sat
`default_nettype wire

// File: rtl/sm_accum_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : sm_accum_ctrl
// Description : Sequences N_TERMS sign-magnitude terms through one adder.
// Revision    : 1.0 - initial release
// ============================================================================
module sm_accum_ctrl
    import sm_pkg::*;
#(
    parameter int N_TERMS = 8,
    parameter int CNT_W   = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic            term_valid,
    input  logic [SM_W-1:0] term,
    output logic            term_ready,
    output logic            sum_valid,
    input  logic            sum_ready,
    output logic [SM_W-1:0] sum,
    output logic            ovf,
    output logic            busy
);

    localparam logic [CNT_W-1:0] c_last = CNT_W'(N_TERMS - 1);

    state_t           r_state;
    sm_word_t         r_acc;
    logic [CNT_W-1:0] r_cnt;
    logic             r_ovf;
    logic             r_term_ready;
    logic             r_sum_valid;
    logic             r_busy;

    sm_word_t         w_sum;
    logic             w_sat;
    logic             w_accept;

    sm_add_sat u_add (
        .a   (r_acc),
        .b   (term),
        .y   (w_sum),
        .sat (w_sat)
    );

    assign w_accept = term_valid & r_term_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state      <= IDLE;
            r_acc        <= '0;
            r_cnt        <= '0;
            r_ovf        <= 1'b0;
            r_term_ready <= 1'b0;
            r_sum_valid  <= 1'b0;
            r_busy       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        r_state      <= ACCUM;
                        r_acc        <= '0;
                        r_cnt        <= '0;
                        r_ovf        <= 1'b0;
                        r_term_ready <= 1'b1;
                        r_busy       <= 1'b1;
                    end
                end
                ACCUM: begin
                    if (w_accept) begin
                        r_acc <= w_sum;
                        r_ovf <= r_ovf | w_sat;
                        r_cnt <= r_cnt + 1'b1;
                        if (r_cnt == c_last) begin
                            r_state      <= DONE;
                            r_term_ready <= 1'b0;
                            r_sum_valid  <= 1'b1;
                        end
                    end
                end
                DONE: begin
                    if (sum_ready) begin
                        r_state     <= IDLE;
                        r_sum_valid <= 1'b0;
                        r_busy      <= 1'b0;
                    end
                end
                default: begin
                    r_state      <= IDLE;
                    r_term_ready <= 1'b0;
                    r_sum_valid  <= 1'b0;
                    r_busy       <= 1'b0;
                end
            endcase
        end
    end

    assign term_ready = r_term_ready;
    assign sum_valid  = r_sum_valid;
    assign sum        = r_acc;
    assign ovf        = r_ovf;
    assign busy       = r_busy;

endmodule : sm_accum_ctrl
`default_nettype wire
